// File: rtl/mc_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_datapath - multi-cycle RV32I datapath with one shared memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_datapath #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            regfile_wren,
  input  logic            PC_sel,
  input  logic            PC_target_sel,
  input  logic            ALU_bsel,
  input  logic [1:0]      result_sel,
  input  logic [2:0]      ximm_sel,
  input  logic [3:0]      ALU_control,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] PC,
  output logic            Z,
  output logic [2:0]      phase,
  output logic            retire
);

  localparam int         RIDX_W    = $clog2(REG_COUNT);
  localparam int         SH_W      = $clog2(XLEN);
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } phase_t;

  phase_t phase_q, phase_d;

  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] oldpc_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] aluout_q;
  logic [XLEN-1:0] mdr_q;
  logic [XLEN-1:0] rf_q [REG_COUNT];

  logic [4:0]        rs1_idx, rs2_idx, rd_idx;
  logic              rs1_ok, rs2_ok, rd_ok;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_ext;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   target_base, target_sum, target;
  logic [XLEN-1:0]   link;
  logic [XLEN-1:0]   result;

  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign rd_idx  = ir_q[11:7];

  // x0 and indices beyond the implemented register count read as zero
  assign rs1_ok  = (rs1_idx != 5'd0) && ({1'b0, rs1_idx} < REG_LIMIT);
  assign rs2_ok  = (rs2_idx != 5'd0) && ({1'b0, rs2_idx} < REG_LIMIT);
  assign rd_ok   = (rd_idx  != 5'd0) && ({1'b0, rd_idx}  < REG_LIMIT);
  assign rs1_val = rs1_ok ? rf_q[rs1_idx[RIDX_W-1:0]] : '0;
  assign rs2_val = rs2_ok ? rf_q[rs2_idx[RIDX_W-1:0]] : '0;

  always_comb begin
    imm32 = 32'd0;
    case (ximm_sel)
      3'd0:    imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      3'd1:    imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2:    imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3:    imm32 = {ir_q[31:12], 12'd0};
      3'd4:    imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));
  assign alu_b   = ALU_bsel ? imm_q : b_q;

  // ALU_control is {funct7[5], funct3}; 4'b1111 passes operand B through (LUI)
  always_comb begin
    alu_res = '0;
    case (ALU_control)
      4'b0000: alu_res = a_q + alu_b;
      4'b1000: alu_res = a_q - alu_b;
      4'b0001: alu_res = a_q << alu_b[SH_W-1:0];
      4'b0010: alu_res = XLEN'($signed(a_q) < $signed(alu_b));
      4'b0011: alu_res = XLEN'(a_q < alu_b);
      4'b0100: alu_res = a_q ^ alu_b;
      4'b0101: alu_res = a_q >> alu_b[SH_W-1:0];
      4'b1101: alu_res = XLEN'($signed(a_q) >>> alu_b[SH_W-1:0]);
      4'b0110: alu_res = a_q | alu_b;
      4'b0111: alu_res = a_q & alu_b;
      4'b1111: alu_res = alu_b;
      default: alu_res = a_q + alu_b;
    endcase
  end

  assign Z = (alu_res == '0);

  assign target_base = PC_target_sel ? a_q : oldpc_q;
  assign target_sum  = target_base + imm_q;
  assign target      = PC_target_sel ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign link        = oldpc_q + XLEN'(4);

  always_comb begin
    result = aluout_q;
    case (result_sel)
      2'd0: result = aluout_q;
      2'd1: result = mdr_q;
      2'd2: result = link;
      2'd3: result = target;
      default: result = aluout_q;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      FETCH:   if (mem_ready) phase_d = DECODE;
      DECODE:  phase_d = EXEC;
      EXEC:    phase_d = (mem_read | mem_write) ? MEM : WB;
      MEM:     if (mem_ready) phase_d = WB;
      WB:      phase_d = FETCH;
      default: phase_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= FETCH;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0000_0013;
      oldpc_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      case (phase_q)
        FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata[31:0];
            oldpc_q <= pc_q;
          end
        end
        DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          imm_q <= imm_ext;
        end
        EXEC: aluout_q <= alu_res;
        MEM: begin
          if (mem_ready) mdr_q <= mem_rdata;
        end
        WB: pc_q <= PC_sel ? target : link;
        default: ;
      endcase
    end
  end

  // Register file is intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && (phase_q == WB) && regfile_wren && rd_ok) begin
      rf_q[rd_idx[RIDX_W-1:0]] <= result;
    end
  end

  assign mem_req     = (phase_q == FETCH) || (phase_q == MEM);
  assign mem_we      = (phase_q == MEM) && mem_write;
  assign mem_addr    = (phase_q == MEM) ? aluout_q : pc_q;
  assign mem_wdata   = b_q;
  assign instruction = ir_q;
  assign PC          = pc_q;
  assign phase       = phase_q;
  assign retire      = (phase_q == WB);

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_datapath - scoreboard bench for mc_datapath with a small decoder model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_datapath;

  typedef struct packed {
    logic       wren, pcsel, tsel, bsel;
    logic [1:0] rsel;
    logic [2:0] xsel;
    logic [3:0] aluc;
    logic       mrd, mwr;
  } ctrl_t;

  typedef struct {
    logic [31:0] pc, npc, ir;
    int          lat;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [31:0] addr, data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rst16;

  logic        mem_ready, mem_req, mem_we, Z, retire;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, instruction, PC;
  logic [2:0]  phase;
  ctrl_t       c0;

  logic        mem_ready16, mem_req16, mem_we16, Z16, retire16;
  logic [31:0] mem_rdata16, mem_addr16, mem_wdata16, instruction16, PC16;
  logic [2:0]  phase16;
  ctrl_t       c1;

  logic [31:0] mem   [0:255];
  logic [31:0] mem16 [0:15];
  assign mem_rdata   = mem[mem_addr[9:2]];
  assign mem_rdata16 = mem16[mem_addr16[5:2]];

  function automatic ctrl_t decode(input logic [31:0] ir, input logic z);
    ctrl_t c;
    c = '0;
    case (ir[6:0])
      7'h13: begin c.wren = 1'b1; c.bsel = 1'b1;
                   c.aluc = {(ir[14:12] == 3'b101) & ir[30], ir[14:12]}; end
      7'h33: begin c.wren = 1'b1; c.aluc = {ir[30], ir[14:12]}; end
      7'h03: begin c.wren = 1'b1; c.bsel = 1'b1; c.rsel = 2'd1; c.mrd = 1'b1; end
      7'h23: begin c.bsel = 1'b1; c.xsel = 3'd1; c.mwr = 1'b1; end
      7'h63: begin c.xsel = 3'd2; c.aluc = 4'b1000;
                   c.pcsel = (ir[14:12] == 3'b000) ? z : ~z; end
      7'h6F: begin c.wren = 1'b1; c.xsel = 3'd4; c.pcsel = 1'b1; c.rsel = 2'd2; end
      7'h67: begin c.wren = 1'b1; c.pcsel = 1'b1; c.tsel = 1'b1; c.rsel = 2'd2; end
      7'h37: begin c.wren = 1'b1; c.xsel = 3'd3; c.bsel = 1'b1; c.aluc = 4'b1111; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign c0 = decode(instruction, Z);
  assign c1 = decode(instruction16, Z16);

  mc_datapath #(.XLEN(32), .RESET_PC(32'h0), .REG_COUNT(32)) dut (
    .clk(clk), .reset(reset),
    .regfile_wren(c0.wren), .PC_sel(c0.pcsel), .PC_target_sel(c0.tsel), .ALU_bsel(c0.bsel),
    .result_sel(c0.rsel), .ximm_sel(c0.xsel), .ALU_control(c0.aluc),
    .mem_read(c0.mrd), .mem_write(c0.mwr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instruction(instruction), .PC(PC), .Z(Z), .phase(phase), .retire(retire)
  );

  mc_datapath #(.XLEN(32), .RESET_PC(32'h0), .REG_COUNT(16)) dut16 (
    .clk(clk), .reset(rst16),
    .regfile_wren(c1.wren), .PC_sel(c1.pcsel), .PC_target_sel(c1.tsel), .ALU_bsel(c1.bsel),
    .result_sel(c1.rsel), .ximm_sel(c1.xsel), .ALU_control(c1.aluc),
    .mem_read(c1.mrd), .mem_write(c1.mwr),
    .mem_rdata(mem_rdata16), .mem_ready(mem_ready16),
    .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
    .instruction(instruction16), .PC(PC16), .Z(Z16), .phase(phase16), .retire(retire16)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t expq[$];
  wr_t  wq[$];
  exp_t pend;
  wr_t  wexp;
  logic pending = 1'b0;
  int   idx = 0, wcnt = 0, lat = 0, need = 0, guard = 0;
  int   fw[16], mw[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] p, np, ir, input int l,
                      input logic w, input logic [4:0] rd, input logic [31:0] v);
    exp_t e;
    e.pc = p; e.npc = np; e.ir = ir; e.lat = l; e.wr = w; e.rd = rd; e.val = v;
    expq.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  // Memory responder plus scoreboard monitor, evaluated mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      mem_ready = 1'b0;
      wcnt      = 0;
      lat       = 0;
      pending   = 1'b0;
    end else begin
      if (mem_req) begin
        need      = (idx < 16) ? ((phase == 3'd0) ? fw[idx] : mw[idx]) : 0;
        mem_ready = (wcnt >= need);
        if (phase == 3'd0 && !mem_ready && idx == 1) begin
          chk("fetch_wait_addr", mem_addr, 32'h4);
          chk("fetch_wait_ir", instruction, 32'h00500093);
        end
        if (mem_ready) begin
          wcnt = 0;
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            if (wq.size() == 0) begin
              vectors++; miscompares++;
              $display("FAIL unexpected_store: got addr 0x%08h, expected no store", mem_addr);
            end else begin
              wexp = wq.pop_front();
              chk("store_addr", mem_addr, wexp.addr);
              chk("store_data", mem_wdata, wexp.data);
            end
          end
        end else begin
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end

      lat++;
      if (pending) begin
        chk("next_pc", PC, pend.npc);
        if (pend.wr) chk("rf_write", dut.rf_q[pend.rd], pend.val);
        pending = 1'b0;
      end
      if (retire) begin
        if (expq.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_retire: got PC 0x%08h, expected no retire", PC);
        end else begin
          pend = expq.pop_front();
          chk("retire_pc", PC, pend.pc);
          chk("retire_ir", instruction, pend.ir);
          chk("latency", lat, pend.lat);
          pending = 1'b1;
        end
        lat = 0;
        idx++;
      end
    end
  end

  initial begin
    reset = 1'b1; rst16 = 1'b1; mem_ready16 = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin fw[i] = 0; mw[i] = 0; mem16[i] = 32'h0; end
    fw[1] = 3; mw[3] = 2; mw[5] = 2; mw[14] = 20;

    mem[0]  = 32'h00500093;  // 0x00 addi x1,x0,5
    mem[1]  = 32'h10000113;  // 0x04 addi x2,x0,0x100
    mem[2]  = 32'h04100293;  // 0x08 addi x5,x0,0x41
    mem[3]  = 32'h00112423;  // 0x0C sw   x1,8(x2)
    mem[4]  = 32'h000280E7;  // 0x10 jalr x1,0(x5)
    mem[6]  = 32'h00600113;  // 0x18 addi x2,x0,6
    mem[7]  = 32'h00108013;  // 0x1C addi x0,x1,1
    mem[8]  = 32'hFE208CE3;  // 0x20 beq  x1,x2,-8
    mem[9]  = 32'h10012523;  // 0x24 sw   x0,0x10A(x2)
    mem[10] = 32'h20102023;  // 0x28 sw   x1,0x200(x0)
    mem[16] = 32'h00812183;  // 0x40 lw   x3,8(x2)
    mem[17] = 32'h00700093;  // 0x44 addi x1,x0,7
    mem[18] = 32'h00700113;  // 0x48 addi x2,x0,7
    mem[19] = 32'hFD5FF06F;  // 0x4C jal  x0,-0x2C

    mem16[0] = 32'h00900213; // addi x4,x0,9
    mem16[1] = 32'h05500193; // addi x3,x0,0x55
    mem16[2] = 32'h00700A13; // addi x20,x0,7
    mem16[3] = 32'h000A01B3; // add  x3,x20,x0
    mem16[4] = 32'h0000006F; // jal  x0,0

    push(32'h00, 32'h04, 32'h00500093, 4, 1'b1, 5'd1, 32'h5);
    push(32'h04, 32'h08, 32'h10000113, 7, 1'b1, 5'd2, 32'h100);
    push(32'h08, 32'h0C, 32'h04100293, 4, 1'b1, 5'd5, 32'h41);
    push(32'h0C, 32'h10, 32'h00112423, 7, 1'b0, 5'd0, 32'h0);
    push(32'h10, 32'h40, 32'h000280E7, 4, 1'b1, 5'd1, 32'h14);
    push(32'h40, 32'h44, 32'h00812183, 7, 1'b1, 5'd3, 32'h5);
    push(32'h44, 32'h48, 32'h00700093, 4, 1'b1, 5'd1, 32'h7);
    push(32'h48, 32'h4C, 32'h00700113, 4, 1'b1, 5'd2, 32'h7);
    push(32'h4C, 32'h20, 32'hFD5FF06F, 4, 1'b0, 5'd0, 32'h0);
    push(32'h20, 32'h18, 32'hFE208CE3, 4, 1'b0, 5'd0, 32'h0);
    push(32'h18, 32'h1C, 32'h00600113, 4, 1'b1, 5'd2, 32'h6);
    push(32'h1C, 32'h20, 32'h00108013, 4, 1'b0, 5'd0, 32'h0);
    push(32'h20, 32'h24, 32'hFE208CE3, 4, 1'b0, 5'd0, 32'h0);
    push(32'h24, 32'h28, 32'h10012523, 5, 1'b0, 5'd0, 32'h0);
    push_wr(32'h108, 32'h5);
    push_wr(32'h110, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_phase", {29'd0, phase}, 32'd0);
    chk("reset_ir", instruction, 32'h00000013);
    chk("reset_retire", {31'd0, retire}, 32'd0);
    chk("reset_mem_req", {31'd0, mem_req}, 32'd1);

    reset = 1'b0; rst16 = 1'b0;
    chk("c1_phase", {29'd0, phase}, 32'd0);
    chk("c1_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    chk("c2_phase", {29'd0, phase}, 32'd1);
    chk("c2_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("c3_phase", {29'd0, phase}, 32'd2);
    chk("c3_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    chk("c4_phase", {29'd0, phase}, 32'd4);
    chk("c4_mem_req", {31'd0, mem_req}, 32'd0);
    chk("c4_retire", {31'd0, retire}, 32'd1);

    guard = 0;
    while (!(idx == 14 && phase == 3'd3) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) begin
      vectors++; miscompares++;
      $display("FAIL timeout: got no store MEM phase within 500 cycles, expected one");
    end else begin
      chk("abort_mem_addr", mem_addr, 32'h200);
      chk("abort_mem_we", {31'd0, mem_we}, 32'd1);
      chk("abort_mem_wdata", mem_wdata, 32'h7);
      @(posedge clk); #1;
      chk("abort_hold_phase", {29'd0, phase}, 32'd3);
      chk("abort_hold_addr", mem_addr, 32'h200);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_pc", PC, 32'h0);
      chk("abort_phase", {29'd0, phase}, 32'd0);
      chk("abort_ir", instruction, 32'h00000013);
      chk("abort_mem_req", {31'd0, mem_req}, 32'd1);
      chk("abort_retire", {31'd0, retire}, 32'd0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_store", mem[128], 32'h0);
    chk("rc16_x4_kept", dut16.rf_q[4], 32'h9);
    chk("rc16_x20_reads_zero", dut16.rf_q[3], 32'h0);
    chk("rc16_loop_pc", PC16, 32'h10);
    chk("retires_left", expq.size(), 32'd0);
    chk("stores_left", wq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
